// File: rtl/cfg_loader_pkg.sv
// Shared state encoding, default region sizes and counter sizing helpers for the BL/WL loader.
package cfg_loader_pkg;

  localparam int unsigned DEF_BL_WIDTH = 514;
  localparam int unsigned DEF_WL_WIDTH = 407;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_WL_PULSE = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } cfg_state_t;

  // Input words needed to fill one bit-line row.
  function automatic int unsigned words_per_row(input int unsigned bl_w, input int unsigned data_w);
    return (bl_w + data_w - 1) / data_w;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned row_cnt_w(input int unsigned wl_w);
    return cnt_w(wl_w);
  endfunction

  function automatic int unsigned word_cnt_w(input int unsigned bl_w, input int unsigned data_w);
    return cnt_w(words_per_row(bl_w, data_w));
  endfunction

endpackage

// File: rtl/bl_row_assembler.sv
// Bit-line row register: writes one input word into its slice of the row, dropping bits past the row end.
module bl_row_assembler
  import cfg_loader_pkg::*;
#(
  parameter int unsigned BL_WIDTH = DEF_BL_WIDTH,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       wr_en,
  input  logic [word_cnt_w(BL_WIDTH, DATA_W)-1:0]    wr_idx,
  input  logic [DATA_W-1:0]                          wr_data,
  output logic [0:BL_WIDTH-1]                        bl
);

  localparam int unsigned WORD_W = word_cnt_w(BL_WIDTH, DATA_W);

  // Each row bit belongs to exactly one word slot; the last slot simply has fewer bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bl <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BL_WIDTH; i++) begin
        if (wr_idx == WORD_W'(i / DATA_W)) begin
          bl[i] <= wr_data[i % DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/bl_wl_config_loader.sv
// Memory-bank configuration writer: assembles bit-line rows from a word stream and strobes word lines in order.
module bl_wl_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned BL_WIDTH = DEF_BL_WIDTH,
  parameter int unsigned WL_WIDTH = DEF_WL_WIDTH,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WL_PULSE = DEF_WL_PULSE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:WL_WIDTH-1] wl,
  output logic                busy,
  output logic                done
);

  localparam int unsigned WPR    = words_per_row(BL_WIDTH, DATA_W);
  localparam int unsigned ROW_W  = row_cnt_w(WL_WIDTH);
  localparam int unsigned WORD_W = word_cnt_w(BL_WIDTH, DATA_W);
  localparam int unsigned PCNT_W = cnt_w(WL_PULSE);

  cfg_state_t          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [0:WL_WIDTH-1] wl_d;
  logic                in_ready_d;
  logic                busy_d;
  logic                done_d;
  logic                accept;

  // in_ready is a pure decode of LOAD, so it gates the handshake directly.
  assign accept = in_valid & in_ready;

  bl_row_assembler #(
    .BL_WIDTH (BL_WIDTH),
    .DATA_W   (DATA_W)
  ) u_row (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_idx  (word_q),
    .wr_data (in_data),
    .bl      (bl)
  );

  // Next-state, counters and registered-output decode of the next state.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_d     = word_q;
    pcnt_d     = pcnt_q;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wl_d       = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          row_d   = '0;
          word_d  = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (word_q == WORD_W'(WPR - 1)) begin
            word_d  = '0;
            state_d = SETUP;
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end
      SETUP: begin
        pcnt_d  = '0;
        state_d = PULSE;
      end
      PULSE: begin
        if (pcnt_q == PCNT_W'(WL_PULSE - 1)) begin
          state_d = HOLD;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      HOLD: begin
        if (row_q == ROW_W'(WL_WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          word_d  = '0;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d inside {LOAD, SETUP, PULSE, HOLD});
    done_d     = (state_d == DONE);
    if (state_d == PULSE) begin
      for (int unsigned i = 0; i < WL_WIDTH; i++) begin
        wl_d[i] = (row_d == ROW_W'(i));
      end
    end
  end

  // State, counters and outputs; reset drops every word line immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      word_q   <= '0;
      pcnt_q   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wl       <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      word_q   <= word_d;
      pcnt_q   <= pcnt_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      wl       <= wl_d;
    end
  end

endmodule

// File: tb/tb_bl_wl_config_loader.sv
// Bench for bl_wl_config_loader: small, truncating and full-size instances checked against a timing/data model.
`timescale 1ns/1ps
module tb_bl_wl_config_loader;

  localparam int A_BL = 8,   A_WL = 3,   A_DW = 4,  A_PULSE = 2, A_WPR = 2;
  localparam int B_BL = 6,   B_WL = 2,   B_DW = 4,  B_PULSE = 1, B_WPR = 2;
  localparam int C_BL = 514, C_WL = 407, C_DW = 32, C_PULSE = 2, C_WPR = 17;
  localparam int MAXE = 48;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            start_a, in_valid_a, in_ready_a, busy_a, done_a;
  logic [A_DW-1:0] in_data_a;
  logic [0:A_BL-1] bl_a;
  logic [0:A_WL-1] wl_a;

  logic            start_b, in_valid_b, in_ready_b, busy_b, done_b;
  logic [B_DW-1:0] in_data_b;
  logic [0:B_BL-1] bl_b;
  logic [0:B_WL-1] wl_b;

  logic            start_c, in_valid_c, in_ready_c, busy_c, done_c;
  logic [C_DW-1:0] in_data_c;
  logic [0:C_BL-1] bl_c;
  logic [0:C_WL-1] wl_c;

  int total = 0;
  int bad = 0;
  logic [3:0] words_a [6];

  bl_wl_config_loader #(.BL_WIDTH(A_BL), .WL_WIDTH(A_WL), .DATA_W(A_DW), .WL_PULSE(A_PULSE)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_ready(in_ready_a), .bl(bl_a), .wl(wl_a), .busy(busy_a), .done(done_a));

  bl_wl_config_loader #(.BL_WIDTH(B_BL), .WL_WIDTH(B_WL), .DATA_W(B_DW), .WL_PULSE(B_PULSE)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .bl(bl_b), .wl(wl_b), .busy(busy_b), .done(done_b));

  bl_wl_config_loader dut_c (
    .clk(clk), .reset(reset), .start(start_c), .in_valid(in_valid_c), .in_data(in_data_c),
    .in_ready(in_ready_c), .bl(bl_c), .wl(wl_c), .busy(busy_c), .done(done_c));

  // One full load on instance A; expected timing derived from the row-timing rules, edge c = c-th edge after start.
  task automatic run_seq_a(input string name, input int gap_at, input int gap_len, input int glitch_at);
    int         exp_wl [MAXE];
    int         exp_row [MAXE];
    bit         exp_busy [MAXE];
    bit         exp_done [MAXE];
    bit         exp_rdy [MAXE];
    bit         acc [MAXE];
    bit         vld [MAXE];
    logic [7:0] rowv [A_WL];
    int         e, n, ls, done_edge, k, nrun;
    logic [2:0] wlv, wl_exp;
    logic [7:0] blv;

    for (int c = 0; c < MAXE; c++) begin
      exp_wl[c] = -1; exp_row[c] = -1; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
      exp_rdy[c] = 1'b0; acc[c] = 1'b0;
      vld[c] = !(c >= gap_at && c < gap_at + gap_len);
    end
    for (int r = 0; r < A_WL; r++) rowv[r] = {words_a[2*r+1], words_a[2*r]};

    e = 0;
    for (int r = 0; r < A_WL; r++) begin
      ls = e;
      n = 0;
      while (n < A_WPR) begin
        e++;
        if (vld[e]) begin n++; acc[e] = 1'b1; end
      end
      for (int c = ls; c < e; c++) exp_rdy[c] = 1'b1;
      for (int c = e; c <= e + A_PULSE + 1; c++) exp_row[c] = r;
      for (int c = e + 1; c <= e + A_PULSE; c++) exp_wl[c] = r;
      e = e + A_PULSE + 2;
    end
    done_edge = e;
    for (int c = 0; c < MAXE; c++) begin
      if (c < done_edge) exp_busy[c] = 1'b1;
      else begin exp_done[c] = 1'b1; exp_row[c] = A_WL - 1; end
    end

    nrun = done_edge + 3;
    k = 0;
    for (int c = 0; c <= nrun; c++) begin
      start_a    = (c == 0) || (c == glitch_at);
      in_valid_a = vld[c];
      in_data_a  = (k < 6) ? words_a[k] : 4'($urandom);
      @(posedge clk);
      if (acc[c]) k++;
      @(negedge clk);
      wlv = {<<{wl_a}};
      wl_exp = (exp_wl[c] >= 0) ? 3'(1 << exp_wl[c]) : 3'b000;
      total++;
      if (wlv !== wl_exp) begin bad++; $display("FAIL %s wl edge=%0d got=%b exp=%b", name, c, wlv, wl_exp); end
      total++;
      if (busy_a !== exp_busy[c]) begin bad++; $display("FAIL %s busy edge=%0d got=%b exp=%b", name, c, busy_a, exp_busy[c]); end
      total++;
      if (done_a !== exp_done[c]) begin bad++; $display("FAIL %s done edge=%0d got=%b exp=%b", name, c, done_a, exp_done[c]); end
      total++;
      if (in_ready_a !== exp_rdy[c]) begin bad++; $display("FAIL %s in_ready edge=%0d got=%b exp=%b", name, c, in_ready_a, exp_rdy[c]); end
      if (exp_row[c] >= 0) begin
        blv = {<<{bl_a}};
        total++;
        if (blv !== rowv[exp_row[c]]) begin
          bad++; $display("FAIL %s bl edge=%0d got=%h exp=%h", name, c, blv, rowv[exp_row[c]]);
        end
      end
    end
    start_a = 1'b0;
    in_valid_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%b exp=0", in_ready_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset done got=%b exp=0", done_a); end
    total++; if (wl_a !== '0) begin bad++; $display("FAIL reset wl got=%b exp=0", wl_a); end
    total++; if (bl_a !== '0) begin bad++; $display("FAIL reset bl got=%b exp=0", bl_a); end
    reset = 1'b0;
    in_valid_a = 1'b1;
    in_data_a = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL idle in_ready cyc=%0d got=%b exp=0", i, in_ready_a); end
      total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL idle busy/done cyc=%0d got=%b%b exp=00", i, busy_a, done_a); end
      total++; if (wl_a !== '0 || bl_a !== '0) begin bad++; $display("FAIL idle wl/bl cyc=%0d got=%b/%b exp=0/0", i, wl_a, bl_a); end
    end
    in_valid_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    words_a[0] = 4'h5; words_a[1] = 4'hA; words_a[2] = 4'h3;
    words_a[3] = 4'hC; words_a[4] = 4'hF; words_a[5] = 4'h0;
    run_seq_a("back_to_back", 99, 0, -1);
  endtask

  task automatic test_valid_gap();
    run_seq_a("valid_gap", 2, 3, -1);
  endtask

  task automatic test_start_ignored();
    run_seq_a("start_ignored", 99, 0, 7);
  endtask

  task automatic test_reset_mid_pulse();
    logic [2:0] wlv;
    for (int c = 0; c <= 9; c++) begin
      start_a = (c == 0);
      in_valid_a = 1'b1;
      in_data_a = 4'($urandom);
      @(negedge clk);
    end
    start_a = 1'b0;
    in_valid_a = 1'b0;
    wlv = {<<{wl_a}};
    total++; if (wlv !== 3'b010) begin bad++; $display("FAIL mid_pulse wl got=%b exp=010", wlv); end
    #2 reset = 1'b1;
    #1;
    total++; if (wl_a !== '0) begin bad++; $display("FAIL async_reset wl got=%b exp=0", wl_a); end
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL async_reset busy/done got=%b%b exp=00", busy_a, done_a); end
    total++; if (in_ready_a !== 1'b0 || bl_a !== '0) begin bad++; $display("FAIL async_reset in_ready/bl got=%b/%b exp=0/0", in_ready_a, bl_a); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) words_a[i] = 4'($urandom);
    run_seq_a("reload", 99, 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 6; i++) words_a[i] = 4'($urandom);
      run_seq_a("random", int'($urandom_range(1, 16)), int'($urandom_range(0, 4)), int'($urandom_range(1, 12)));
    end
  endtask

  // Instance B: 6-bit rows from 4-bit words, so the second word of each row keeps only two bits.
  task automatic test_truncation();
    logic [3:0] wq [4];
    logic [5:0] rowv [B_WL];
    logic [5:0] blv, exp_bl;
    logic [1:0] wlv;
    int idx = 0, rows_seen = 0, plen = 0, cyc = 0;
    logic pending = 1'b0;
    wq[0] = 4'h0; wq[1] = 4'hF; wq[2] = 4'($urandom); wq[3] = 4'($urandom);
    for (int r = 0; r < B_WL; r++) rowv[r] = 6'({wq[2*r+1], wq[2*r]});
    start_b = 1'b1;
    in_valid_b = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    while (!done_b && cyc < 200) begin
      if (pending) idx++;
      in_valid_b = (idx < 4);
      in_data_b = (idx < 4) ? wq[idx] : 4'h0;
      pending = in_valid_b && in_ready_b;
      @(negedge clk);
      cyc++;
      wlv = {<<{wl_b}};
      blv = {<<{bl_b}};
      exp_bl = (rows_seen < B_WL) ? rowv[rows_seen] : 6'h00;
      if (wlv != 2'b00) begin
        total++; if (wlv !== 2'(1 << rows_seen)) begin bad++; $display("FAIL trunc wl row=%0d got=%b exp=%b", rows_seen, wlv, 2'(1 << rows_seen)); end
        total++; if (blv !== exp_bl) begin bad++; $display("FAIL trunc bl row=%0d got=%h exp=%h", rows_seen, blv, exp_bl); end
        plen++;
      end else if (plen > 0) begin
        total++; if (plen != B_PULSE) begin bad++; $display("FAIL trunc pulse_len row=%0d got=%0d exp=%0d", rows_seen, plen, B_PULSE); end
        rows_seen++;
        plen = 0;
      end
    end
    in_valid_b = 1'b0;
    total++; if (done_b !== 1'b1) begin bad++; $display("FAIL trunc timeout done got=%b exp=1", done_b); end
    total++; if (rows_seen != B_WL) begin bad++; $display("FAIL trunc rows got=%0d exp=%0d", rows_seen, B_WL); end
    blv = {<<{bl_b}};
    total++; if (blv !== rowv[B_WL-1]) begin bad++; $display("FAIL trunc final_bl got=%h exp=%h", blv, rowv[B_WL-1]); end
  endtask

  // Instance C: default geometry, 407 rows of 17 random words streamed without gaps.
  task automatic test_full_load();
    logic [31:0]     wc [];
    logic [0:C_BL-1] exp_bl;
    logic [0:C_WL-1] exp_wl;
    int idx = 0, rows_seen = 0, plen = 0, cyc = 0, last_rise = 0;
    logic pending = 1'b0;
    wc = new[C_WL * C_WPR];
    foreach (wc[i]) wc[i] = $urandom;
    exp_bl = '0;
    exp_wl = '0;
    start_c = 1'b1;
    in_valid_c = 1'b0;
    @(negedge clk);
    start_c = 1'b0;
    while (!done_c && cyc < 10000) begin
      if (pending) idx++;
      if (idx < C_WL * C_WPR) begin
        in_valid_c = 1'b1;
        in_data_c = wc[idx];
      end else begin
        in_valid_c = 1'b0;
        in_data_c = '0;
      end
      pending = in_valid_c && in_ready_c;
      @(negedge clk);
      cyc++;
      if (|wl_c) begin
        if (plen == 0) begin
          if (rows_seen > 0) begin
            total++;
            if (cyc - last_rise != C_WPR + C_PULSE + 2) begin
              bad++; $display("FAIL full row_period row=%0d got=%0d exp=%0d", rows_seen, cyc - last_rise, C_WPR + C_PULSE + 2);
            end
          end
          last_rise = cyc;
          exp_wl = '0;
          if (rows_seen < C_WL) begin
            exp_wl[rows_seen] = 1'b1;
            for (int i = 0; i < C_BL; i++) exp_bl[i] = wc[rows_seen * C_WPR + i / C_DW][i % C_DW];
          end
        end
        total++; if (wl_c !== exp_wl) begin bad++; $display("FAIL full wl row=%0d got=%h exp=%h", rows_seen, wl_c, exp_wl); end
        total++; if (bl_c !== exp_bl) begin bad++; $display("FAIL full bl row=%0d got=%h exp=%h", rows_seen, bl_c, exp_bl); end
        plen++;
      end else if (plen > 0) begin
        total++; if (plen != C_PULSE) begin bad++; $display("FAIL full pulse_len row=%0d got=%0d exp=%0d", rows_seen, plen, C_PULSE); end
        rows_seen++;
        plen = 0;
      end
    end
    in_valid_c = 1'b0;
    total++; if (done_c !== 1'b1) begin bad++; $display("FAIL full timeout done got=%b exp=1", done_c); end
    total++; if (rows_seen != C_WL) begin bad++; $display("FAIL full rows got=%0d exp=%0d", rows_seen, C_WL); end
    total++; if (idx != C_WL * C_WPR) begin bad++; $display("FAIL full words got=%0d exp=%0d", idx, C_WL * C_WPR); end
  endtask

  initial begin
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    start_c = 1'b0; in_valid_c = 1'b0; in_data_c = '0;
    test_reset();
    test_back_to_back();
    test_valid_gap();
    test_start_ignored();
    test_reset_mid_pulse();
    test_random();
    test_truncation();
    test_full_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bl_wl_config_loader.md
# bl_wl_config_loader

Memory-bank configuration writer for the fabric's `bl_config_region_0` / `wl_config_region_0` ports. It accepts the bitstream as a stream of fixed-width words and assembles one bit-line row at a time. It then pulses the matching word line one-hot, so the fabric latches each row in turn. The block sits between the configuration source (host/SPI/JTAG front end) and `fpga_top`, replacing behavioural bitstream loading in bitstream-level benches.

## Interface
- `BL_WIDTH`, default 514: bit lines per row, width of `bl`.
- `WL_WIDTH`, default 407: word lines, number of rows.
- `DATA_W`, default 32: input word width.
- `WL_PULSE`, default 2: word-line high time in cycles, at least 1.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1: the block's single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `start`  in  1: one-cycle request to begin a full configuration; ignored unless the block is idle or done.
- `in_valid`  in  1: input word valid.
- `in_data`  in  DATA_W: bitstream word.
- `in_ready`  out  1: input word accepted when `in_valid & in_ready`.
- `bl`  out  [0:BL_WIDTH-1]: bit-line data.
- `wl`  out  [0:WL_WIDTH-1]: one-hot word-line strobe.
- `busy`  out  1: configuration in progress.
- `done`  out  1: all rows written; held until the next `start` or `reset`.

## Operation
- Words per row: `WPR = ceil(BL_WIDTH/DATA_W)`. The defaults give 17, so a full load is 17 × 407 = 6919 words.
- Bit mapping: `in_data[j]` of the k-th word of a row maps to `bl[k*DATA_W + j]`. In the last word, bits at or above `BL_WIDTH - (WPR-1)*DATA_W` are discarded.
- Rows are written in order: `wl[0]` first, `wl[WL_WIDTH-1]` last.
- FSM states and transitions:
  - `IDLE`: moves to `LOAD` on `start`, with row=0 and word=0.
  - `LOAD`: `in_ready=1`. Each handshake stores one word and increments word. After the `WPR`-th word the block goes to `SETUP`.
  - `SETUP`: 1 cycle. `bl` is stable and `wl` is all zero.
  - `PULSE`: `WL_PULSE` cycles with `wl[row]=1` and `bl` stable.
  - `HOLD`: 1 cycle with `wl=0` and `bl` stable. Then, if `row==WL_WIDTH-1`, go to `DONE`; otherwise increment row, set word=0, and return to `LOAD`.
  - `DONE`: `done=1`. `start` returns the block to `LOAD`.
- `in_ready` is 0 outside `LOAD`. Words presented at those times are not consumed.
- `bl` changes only in `LOAD`, so it is never modified while any `wl` bit is high.
- `start` while `busy` is ignored and does not restart the block.

## Timing
- Reset values: `bl=0`, `wl=0`, `in_ready=0`, `busy=0`, `done=0`, state `IDLE`.
- Reset asserted mid-row or mid-pulse immediately forces `wl=0` (asynchronous). The partial load is abandoned.
- `busy` is high from the cycle after `start` is sampled until `DONE` is entered. `done` rises in the same cycle that `busy` falls.
- `in_ready` rises the cycle after `start` is sampled.
- With `in_valid` held high, each row takes `WPR + 1 + WL_PULSE + 1` cycles (defaults: 21).
- `in_valid` gaps stall `LOAD` only. `SETUP`, `PULSE` and `HOLD` are never stretched or shortened by input activity.
- `wl` is registered and glitch-free. At most one bit is high in any cycle.
- Row and word counters use `$clog2` widths. The word counter wraps to 0 at `WPR`, and the row counter does not advance past `WL_WIDTH-1`.

## Structure
- Shared package `cfg_loader_pkg`:
  - state enum `{IDLE, LOAD, SETUP, PULSE, HOLD, DONE}`;
  - `WPR`, row/word counter width functions;
  - default region sizes 514/407, shared with bench pin-mapping code.
- Sub-module `bl_row_assembler`: word-indexed write into the `BL_WIDTH` row register, including last-word truncation. The FSM, counters and `wl` decode stay in the top.

## Test plan
Unless stated, benches use `BL_WIDTH=8, WL_WIDTH=3, DATA_W=4, WL_PULSE=2`, so `WPR=2`.
- Reset, then idle with `in_valid=1`: `in_ready=0`, all outputs 0, no word consumed for 10 cycles.
- `start`, words 0x5,0xA,0x3,0xC,0xF,0x0 streamed back-to-back:
  - `bl` reads 0xA5, then 0xC3, then 0x0F;
  - `wl` shows 001, 010, 100, each high for exactly 2 cycles, with 6 cycles per row;
  - `done` rises after the third `HOLD`.
- Same load with a 3-cycle `in_valid` gap after the first word: row timing is delayed by 3 cycles and the data is unchanged.
- `start` pulsed during row 1: ignored, and the sequence and final `done` are unchanged.
- `reset` asserted during `PULSE` of row 1: `wl` goes to 0 asynchronously and `busy`/`done` are 0. A subsequent `start` reloads from row 0.
- `BL_WIDTH=6, DATA_W=4`: the last word 0xF sets only `bl[4:5]`, with upper bits dropped. Also run the default-parameter full load of 6919 words, checked against the `fpga_top` 2-bit multiplier (`z=a*b` for all 16 input combinations).
